// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one sram-like memory bus between the fetch (I) and memory-stage (D)
//   requesters. Address phases are handshaken with addr_ok. Responses return
//   strictly in order with data_ok and are routed back using an owner-tag FIFO.
//   D has fixed priority. I gets priority after losing STARVE_LIM consecutive
//   cycles to D. A grant that the bus has not yet accepted is locked until it
//   is accepted.
// Ports
//   clk, rst                 clock, async active-low reset
//   i_req/i_addr             fetch request (read only)
//   i_addr_ok/i_data_ok      fetch handshakes
//   i_rdata                  fetch read data
//   d_req/d_wr/d_size/
//   d_wstrb/d_addr/d_wdata   data request
//   d_addr_ok/d_data_ok      data handshakes
//   d_rdata                  data read data
//   bus_*                    shared bus master side
//   outst_cnt                outstanding transaction count
//   resp_err                 sticky flag for a response with nothing outstanding
module mem_bus_arbiter #(
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [2:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [2:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  outst_cnt,
    output logic        resp_err
);

    localparam int PW = $clog2(MAX_OUTST);

    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} own_e;

    logic                 lock_q, lock_d;
    own_e                 lock_own_q, lock_own_d;
    logic [7:0]           starve_q, starve_d;
    logic [MAX_OUTST-1:0] fifo_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [3:0]           outst_q, outst_d;
    logic                 resp_err_q;

    own_e own;
    logic own_vld, full, empty, push, pop;
    own_e head;

    // Grant selection. While locked the owner is fixed; its own req still
    // qualifies the grant so a flushed (dropped) request releases the lock.
    always_comb begin
        own_vld = 1'b0;
        own     = OWN_I;
        if (lock_q) begin
            own     = lock_own_q;
            own_vld = (lock_own_q == OWN_D) ? d_req : i_req;
        end else if (d_req && !(i_req && starve_q >= 8'(STARVE_LIM))) begin
            own     = OWN_D;
            own_vld = 1'b1;
        end else if (i_req) begin
            own     = OWN_I;
            own_vld = 1'b1;
        end
    end

    assign full  = (outst_q == 4'(MAX_OUTST));
    assign empty = (outst_q == 4'd0);
    assign bus_req = own_vld && !full;
    assign push  = bus_req && bus_addr_ok;
    assign pop   = bus_data_ok && !empty;
    assign head  = own_e'(fifo_q[rd_ptr_q]);

    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = 3'd0;
        bus_wstrb = 4'd0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        if (own_vld) begin
            if (own == OWN_D) begin
                bus_wr    = d_wr;
                bus_size  = d_size;
                bus_wstrb = d_wstrb;
                bus_addr  = d_addr;
                bus_wdata = d_wdata;
            end else begin
                bus_size  = 3'd2;
                bus_addr  = i_addr;
            end
        end
    end

    assign i_addr_ok = push && (own == OWN_I);
    assign d_addr_ok = push && (own == OWN_D);
    assign i_data_ok = pop && (head == OWN_I);
    assign d_data_ok = pop && (head == OWN_D);
    assign i_rdata   = bus_rdata;
    assign d_rdata   = bus_rdata;
    assign outst_cnt = outst_q;
    assign resp_err  = resp_err_q;

    always_comb begin
        lock_d     = lock_q;
        lock_own_d = lock_own_q;
        if (bus_req && !bus_addr_ok) begin
            lock_d     = 1'b1;
            lock_own_d = own;
        end else if (push || (lock_q && !own_vld)) begin
            lock_d     = 1'b0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_addr_ok)
            starve_d = 8'd0;
        else if (d_addr_ok && starve_q != 8'hFF)
            starve_d = starve_q + 8'd1;
    end

    always_comb begin
        outst_d = outst_q;
        if (push && !pop)
            outst_d = outst_q + 4'd1;
        else if (pop && !push)
            outst_d = outst_q - 4'd1;
    end

    // Pointers wrap explicitly so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q     <= 1'b0;
            lock_own_q <= OWN_I;
            starve_q   <= 8'd0;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            outst_q    <= 4'd0;
            resp_err_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            starve_q   <= starve_d;
            outst_q    <= outst_d;
            // A response with nothing outstanding includes one that lands in
            // the same cycle as the first accept: it is never credited to it.
            if (bus_data_ok && empty)
                resp_err_q <= 1'b1;
            if (push) begin
                fifo_q[wr_ptr_q] <= own;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [2:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        bus_req, bus_wr;
    logic [2:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic [3:0]  outst_cnt;
    logic        resp_err;

    int cmp = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_OUTST(4), .STARVE_LIM(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
        .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .outst_cnt(outst_cnt), .resp_err(resp_err)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_req = 1'($urandom); i_addr = $urandom;
            d_req = 1'($urandom); d_wr = 1'($urandom); d_addr = $urandom;
            bus_addr_ok = 1'($urandom); bus_data_ok = 1'($urandom);
            bus_rdata = $urandom;
            tick();
        end
        cmp++; if ({outst_cnt, resp_err} !== 5'd0) begin errs++;
            $display("FAIL reset_regs got cnt=%0d err=%b want 0/0", outst_cnt, resp_err); end
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        #1;
        cmp++; if ({bus_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 5'd0) begin errs++;
            $display("FAIL reset_idle_outs got %b want 00000",
                     {bus_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}); end
        cmp++; if ({bus_addr, bus_wdata, bus_wstrb, bus_size, bus_wr} !== 72'd0) begin errs++;
            $display("FAIL reset_bus_fields got addr=%h wd=%h st=%b sz=%0d wr=%b want 0",
                     bus_addr, bus_wdata, bus_wstrb, bus_size, bus_wr); end
        cmp++; if ({outst_cnt, resp_err} !== 5'd0) begin errs++;
            $display("FAIL reset_after got cnt=%0d err=%b want 0/0", outst_cnt, resp_err); end
    endtask

    task automatic test_priority();
        i_req = 1; i_addr = 32'h1000;
        d_req = 1; d_wr = 1; d_size = 3'd2; d_wstrb = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        bus_addr_ok = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp++; if ({i_addr_ok, d_addr_ok} !== 2'b01) begin errs++;
                $display("FAIL prio_accept[%0d] got i,d=%b want 01", k, {i_addr_ok, d_addr_ok}); end
            cmp++; if ({bus_wr, bus_wstrb, bus_addr, bus_wdata} !== {1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF}) begin errs++;
                $display("FAIL prio_bus_mux[%0d] got addr=%h wd=%h want 2000/deadbeef", k, bus_addr, bus_wdata); end
            tick();
        end
        idle_inputs();
        #1;
        cmp++; if (outst_cnt !== 4'd3) begin errs++;
            $display("FAIL prio_outst got %0d want 3", outst_cnt); end
        bus_data_ok = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            cmp++; if ({i_data_ok, d_data_ok} !== 2'b01) begin errs++;
                $display("FAIL prio_resp[%0d] got i,d=%b want 01", k, {i_data_ok, d_data_ok}); end
            tick();
        end
        bus_data_ok = 0;
        #1;
        cmp++; if ({outst_cnt, resp_err} !== 5'd0) begin errs++;
            $display("FAIL prio_drain got cnt=%0d err=%b want 0/0", outst_cnt, resp_err); end
    endtask

    task automatic test_lock();
        i_req = 1; i_addr = 32'h3000; bus_addr_ok = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            cmp++; if ({bus_req, i_addr_ok, bus_size, bus_wstrb, bus_addr} !== {1'b1, 1'b0, 3'd2, 4'h0, 32'h3000}) begin errs++;
                $display("FAIL lock_wait[%0d] got req=%b ok=%b sz=%0d st=%b a=%h want 1/0/2/0000/3000",
                         k, bus_req, i_addr_ok, bus_size, bus_wstrb, bus_addr); end
            tick();
        end
        d_req = 1; d_addr = 32'h4000; d_wr = 0; d_size = 3'd0; bus_addr_ok = 1;
        #1;
        cmp++; if ({i_addr_ok, d_addr_ok} !== 2'b10) begin errs++;
            $display("FAIL lock_hold got i,d=%b want 10", {i_addr_ok, d_addr_ok}); end
        tick();
        i_req = 0;
        #1;
        cmp++; if ({i_addr_ok, d_addr_ok, bus_addr} !== {2'b01, 32'h4000}) begin errs++;
            $display("FAIL lock_next got i,d=%b a=%h want 01/4000", {i_addr_ok, d_addr_ok}, bus_addr); end
        tick();
        idle_inputs();
        bus_data_ok = 1;
        #1;
        cmp++; if ({i_data_ok, d_data_ok} !== 2'b10) begin errs++;
            $display("FAIL lock_resp0 got i,d=%b want 10", {i_data_ok, d_data_ok}); end
        tick();
        #1;
        cmp++; if ({i_data_ok, d_data_ok} !== 2'b01) begin errs++;
            $display("FAIL lock_resp1 got i,d=%b want 01", {i_data_ok, d_data_ok}); end
        tick();
        bus_data_ok = 0;
    endtask

    task automatic test_starvation();
        logic [1:0] exp_a, exp_r;
        i_req = 1; i_addr = 32'h5000; d_req = 1; d_addr = 32'h6000; bus_addr_ok = 1;
        for (int k = 0; k < 10; k++) begin
            bus_data_ok = (k > 0);
            #1;
            exp_a = (k == 8) ? 2'b10 : 2'b01;
            exp_r = (k == 0) ? 2'b00 : (k == 9) ? 2'b10 : 2'b01;
            cmp++; if ({i_addr_ok, d_addr_ok} !== exp_a) begin errs++;
                $display("FAIL starve_accept[%0d] got i,d=%b want %b", k, {i_addr_ok, d_addr_ok}, exp_a); end
            cmp++; if ({i_data_ok, d_data_ok} !== exp_r) begin errs++;
                $display("FAIL starve_resp[%0d] got i,d=%b want %b", k, {i_data_ok, d_data_ok}, exp_r); end
            tick();
        end
        idle_inputs();
        bus_data_ok = 1;
        #1;
        cmp++; if ({i_data_ok, d_data_ok} !== 2'b01) begin errs++;
            $display("FAIL starve_last got i,d=%b want 01", {i_data_ok, d_data_ok}); end
        tick();
        bus_data_ok = 0;
        #1;
        cmp++; if ({outst_cnt, resp_err} !== 5'd0) begin errs++;
            $display("FAIL starve_drain got cnt=%0d err=%b want 0/0", outst_cnt, resp_err); end
    endtask

    task automatic test_full();
        d_req = 1; d_addr = 32'h7000; bus_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            cmp++; if (d_addr_ok !== 1'b1) begin errs++;
                $display("FAIL full_fill[%0d] got %b want 1", k, d_addr_ok); end
            tick();
        end
        #1;
        cmp++; if ({bus_req, d_addr_ok, outst_cnt} !== {2'b00, 4'd4}) begin errs++;
            $display("FAIL full_block got req=%b ok=%b cnt=%0d want 0/0/4", bus_req, d_addr_ok, outst_cnt); end
        // Full is sampled this cycle, so only the pop happens.
        bus_data_ok = 1;
        #1;
        cmp++; if ({d_addr_ok, d_data_ok} !== 2'b01) begin errs++;
            $display("FAIL full_pop got ok,data=%b want 01", {d_addr_ok, d_data_ok}); end
        tick();
        #1;
        cmp++; if ({outst_cnt, d_addr_ok, d_data_ok} !== {4'd3, 2'b11}) begin errs++;
            $display("FAIL full_pushpop got cnt=%0d ok,data=%b want 3/11", outst_cnt, {d_addr_ok, d_data_ok}); end
        tick();
        idle_inputs();
        #1;
        cmp++; if (outst_cnt !== 4'd3) begin errs++;
            $display("FAIL full_hold got %0d want 3", outst_cnt); end
        bus_data_ok = 1;
        for (int k = 0; k < 3; k++) tick();
        bus_data_ok = 0;
        #1;
        cmp++; if ({outst_cnt, resp_err} !== 5'd0) begin errs++;
            $display("FAIL full_drain got cnt=%0d err=%b want 0/0", outst_cnt, resp_err); end
    endtask

    task automatic test_order_err();
        logic [31:0] rd [3];
        logic [1:0]  who [3];
        rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC;
        who[0] = 2'b10; who[1] = 2'b01; who[2] = 2'b10;
        bus_addr_ok = 1;
        for (int k = 0; k < 3; k++) begin
            i_req = who[k][1]; d_req = who[k][0]; i_addr = 32'h100 + k; d_addr = 32'h200 + k;
            tick();
        end
        idle_inputs();
        bus_data_ok = 1;
        for (int k = 0; k < 3; k++) begin
            bus_rdata = rd[k];
            #1;
            cmp++; if ({i_data_ok, d_data_ok} !== who[k]) begin errs++;
                $display("FAIL order_owner[%0d] got i,d=%b want %b", k, {i_data_ok, d_data_ok}, who[k]); end
            cmp++; if ((who[k][1] ? i_rdata : d_rdata) !== rd[k]) begin errs++;
                $display("FAIL order_rdata[%0d] got %h want %h", k, who[k][1] ? i_rdata : d_rdata, rd[k]); end
            tick();
        end
        cmp++; if (resp_err !== 1'b0) begin errs++;
            $display("FAIL err_before got %b want 0", resp_err); end
        bus_rdata = 32'hD;
        #1;
        cmp++; if ({i_data_ok, d_data_ok} !== 2'b00) begin errs++;
            $display("FAIL err_route got i,d=%b want 00", {i_data_ok, d_data_ok}); end
        tick();
        bus_data_ok = 0;
        tick();
        cmp++; if ({resp_err, outst_cnt} !== {1'b1, 4'd0}) begin errs++;
            $display("FAIL err_sticky got err=%b cnt=%0d want 1/0", resp_err, outst_cnt); end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_priority();
        test_lock();
        test_starvation();
        test_full();
        test_order_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
